// File: rtl/servo_seq_pkg.sv
// Shared definitions for the servo move sequencer: state encoding, default geometry, clamp helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package servo_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STEP_WAIT = 3'd1,
    WRITE     = 3'd2,
    DONE      = 3'd3,
    INIT      = 3'd4
  } seq_state_t;

  localparam int DEF_N_SERVO     = 8;
  localparam int DEF_POS_W       = 16;
  localparam int DEF_POS_MIN     = 50;
  localparam int DEF_POS_MAX     = 250;
  localparam int DEF_CENTER      = 150;
  localparam int DEF_STEP_SIZE   = 10;
  localparam int DEF_STEP_DIV    = 50000;
  localparam int DEF_ADDR_STRIDE = 4;

  // Unsigned clamp into [lo, hi]; done at 32 bits so any POS_W up to 32 fits.
  function automatic logic [31:0] clamp_pos(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_step_tick.sv
// Step-period divider: counts enabled cycles and pulses o_tick on the STEP_DIV-th one.
// Latency: o_tick asserts in the STEP_DIV-th consecutive enabled cycle after a clear.
// Backpressure: none; i_clr restarts the period, i_en low freezes the count.
module servo_step_tick
  import servo_seq_pkg::*;
#(
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // Count enabled cycles; wrap to zero on the tick so the next period starts cleanly.
  always_ff @(posedge clk) begin
    if (rst || i_clr || o_tick) r_cnt <= '0;
    else if (i_en)              r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/servo_move_seq.sv
// Command-driven slew sequencer: moves one servo toward a clamped target in STEP_SIZE steps, one PWM register write per step.
// Latency: k-step move = accept edge + k*(STEP_DIV+1) cycles + 1 DONE cycle; equal target gives one write the cycle after accept.
// Backpressure: cmd_ready only in IDLE, commands offered while busy are dropped. Optional SERVO_SEQ_INIT_WRITE_EN: write CENTER to all channels after reset.
module servo_move_seq
  import servo_seq_pkg::*;
#(
  parameter int N_SERVO     = DEF_N_SERVO,
  parameter int POS_W       = DEF_POS_W,
  parameter int POS_MIN     = DEF_POS_MIN,
  parameter int POS_MAX     = DEF_POS_MAX,
  parameter int CENTER      = DEF_CENTER,
  parameter int STEP_SIZE   = DEF_STEP_SIZE,
  parameter int STEP_DIV    = DEF_STEP_DIV,
  parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_servo,
  input  logic [POS_W-1:0] cmd_pos,
  output logic             busy,
  output logic             done,
  output logic             cs,
  output logic             wr,
  output logic             rd,
  output logic [7:0]       addr,
  output logic [31:0]      d_out
);

`ifdef SERVO_SEQ_INIT_WRITE_EN
  localparam seq_state_t RST_STATE = INIT;
`else
  localparam seq_state_t RST_STATE = IDLE;
`endif

  seq_state_t       r_state, w_next;
  logic [2:0]       r_sel;
  logic [POS_W-1:0] r_tgt;
  logic [POS_W-1:0] r_cur_pos [N_SERVO];
`ifdef SERVO_SEQ_INIT_WRITE_EN
  logic [2:0]       r_init_idx;
`endif

  logic             w_accept;
  logic             w_tick;
  logic             w_cmd_ok;
  logic [POS_W-1:0] w_cmd_cur;
  logic [POS_W-1:0] w_cmd_tgt;
  logic [POS_W-1:0] w_cur;
  logic             w_up;
  logic [POS_W-1:0] w_diff;
  logic [POS_W-1:0] w_step;
  logic [POS_W-1:0] w_new_pos;

  assign rd        = 1'b0;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_cmd_tgt = POS_W'(clamp_pos(32'(cmd_pos), 32'(POS_MIN), 32'(POS_MAX)));

  // Channel lookups: current position of the incoming channel and of the latched one.
  // Loops keep indices in range when N_SERVO is smaller than the 3-bit selector space.
  always_comb begin
    w_cmd_ok  = 1'b0;
    w_cmd_cur = '0;
    w_cur     = '0;
    for (int i = 0; i < N_SERVO; i++) begin
      if (cmd_servo == 3'(i)) begin
        w_cmd_ok  = 1'b1;
        w_cmd_cur = r_cur_pos[i];
      end
      if (r_sel == 3'(i)) w_cur = r_cur_pos[i];
    end
  end

  // Bounded step toward target; final step shrinks so the position never overshoots.
  assign w_up      = r_tgt > w_cur;
  assign w_diff    = w_up ? (r_tgt - w_cur) : (w_cur - r_tgt);
  assign w_step    = (w_diff > POS_W'(STEP_SIZE)) ? POS_W'(STEP_SIZE) : w_diff;
  assign w_new_pos = w_up ? (w_cur + w_step) : (w_cur - w_step);

  servo_step_tick #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_en   (r_state == STEP_WAIT),
    .o_tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RST_STATE;
    else     r_state <= w_next;
  end

  // Next state and bus outputs; everything forced quiet while rst is high so a reset aborts at once.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cs        = 1'b0;
    wr        = 1'b0;
    addr      = '0;
    d_out     = '0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            if (!w_cmd_ok)                   w_next = DONE;
            else if (w_cmd_tgt == w_cmd_cur) w_next = WRITE;
            else                             w_next = STEP_WAIT;
          end
        end
        STEP_WAIT: begin
          busy = 1'b1;
          if (w_tick) w_next = WRITE;
        end
        WRITE: begin
          busy  = 1'b1;
          cs    = 1'b1;
          wr    = 1'b1;
          addr  = 8'(32'(r_sel) * 32'(ADDR_STRIDE));
          d_out = 32'(w_cur);
          w_next = (w_cur == r_tgt) ? DONE : STEP_WAIT;
        end
        DONE: begin
          busy   = 1'b1;
          done   = 1'b1;
          w_next = IDLE;
        end
`ifdef SERVO_SEQ_INIT_WRITE_EN
        INIT: begin
          busy  = 1'b1;
          cs    = 1'b1;
          wr    = 1'b1;
          addr  = 8'(32'(r_init_idx) * 32'(ADDR_STRIDE));
          d_out = 32'(CENTER);
          if (r_init_idx == 3'(N_SERVO - 1)) w_next = IDLE;
        end
`endif
        default: w_next = IDLE;
      endcase
    end
  end

  // Command latch and per-channel position; positions only change on a step tick of the selected channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
      r_tgt <= POS_W'(CENTER);
      for (int i = 0; i < N_SERVO; i++) r_cur_pos[i] <= POS_W'(CENTER);
    end else begin
      if (w_accept) begin
        r_sel <= cmd_servo;
        r_tgt <= w_cmd_tgt;
      end
      if (r_state == STEP_WAIT && w_tick) begin
        for (int i = 0; i < N_SERVO; i++) begin
          if (r_sel == 3'(i)) r_cur_pos[i] <= w_new_pos;
        end
      end
    end
  end

`ifdef SERVO_SEQ_INIT_WRITE_EN
  // Channel index for the post-reset CENTER sweep.
  always_ff @(posedge clk) begin
    if (rst)                  r_init_idx <= '0;
    else if (r_state == INIT) r_init_idx <= r_init_idx + 3'd1;
  end
`endif

endmodule

// File: tb/tb_servo_move_seq.sv
// Directed bench for servo_move_seq with a short step period.
// Latency: expected write/done cycles are derived from STEP_DIV relative to the accept edge.
// Backpressure: exercises dropped commands while busy and reset mid-move.
module tb_servo_move_seq;

  localparam int STEP_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_servo = 3'd0;
  logic [15:0] cmd_pos = 16'd0;
  logic        busy, done, cs, wr, rd;
  logic [7:0]  addr;
  logic [31:0] d_out;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int acc, dc, nq, tmp;

  servo_move_seq #(
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_servo (cmd_servo),
    .cmd_pos   (cmd_pos),
    .busy      (busy),
    .done      (done),
    .cs        (cs),
    .wr        (wr),
    .rd        (rd),
    .addr      (addr),
    .d_out     (d_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every bus write with the cycle it was seen in.
  always @(negedge clk) begin
    if (cs === 1'b1 && wr === 1'b1) begin
      wq_addr.push_back(int'(addr));
      wq_data.push_back(int'(d_out));
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Offer a command for one cycle; a returns the cycle count of the offering edge.
  task automatic issue(input int s, input int p, output int a);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_servo = 3'(s);
    cmd_pos   = 16'(p);
    @(negedge clk);
    cmd_valid = 1'b0;
    a = cyc;
  endtask

  task automatic wait_done(input int budget, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ready(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_cs",        32'(cs),        32'd0);
    check("rst_wr",        32'(wr),        32'd0);
    check("rst_rd",        32'(rd),        32'd0);
    check("rst_addr",      32'(addr),      32'd0);
    check("rst_d_out",     d_out,          32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef SERVO_SEQ_INIT_WRITE_EN
    wait_ready(30);
    check("init_count", 32'(wq_addr.size()), 32'd8);
    for (int i = 0; i < 8 && i < wq_addr.size(); i++) begin
      check("init_addr", 32'(wq_addr[i]), 32'(i * 4));
      check("init_data", 32'(wq_data[i]), 32'd150);
      check("init_cyc",  32'(wq_cyc[i]),  32'(wq_cyc[0] + i));
    end
`else
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_cs",    32'(cs),        32'd0);
    check("post_rst_writes", 32'(wq_addr.size()), 32'd0);
`endif

    // Servo 2: 150 -> 175 in steps 160, 170, 175.
    clear_q();
    issue(2, 175, acc);
    wait_done(200, dc);
    check("s2_count", 32'(wq_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      check("s2_addr", 32'(wq_addr[i]), 32'h08);
      check("s2_data", 32'(wq_data[i]), (i == 2) ? 32'd175 : 32'(160 + 10 * i));
      check("s2_cyc",  32'(wq_cyc[i]),  32'(acc + STEP_DIV + (STEP_DIV + 1) * i));
    end
    check("s2_done_cyc", 32'(dc), 32'(acc + 3 * (STEP_DIV + 1)));
    @(negedge clk);
    check("s2_busy_after",  32'(busy),      32'd0);
    check("s2_ready_after", 32'(cmd_ready), 32'd1);
    check("s2_done_pulse",  32'(done),      32'd0);

    // Servo 0: target equals current position, one refresh write right after accept.
    clear_q();
    issue(0, 150, acc);
    wait_done(50, dc);
    check("s0_count", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() > 0) begin
      check("s0_addr", 32'(wq_addr[0]), 32'h00);
      check("s0_data", 32'(wq_data[0]), 32'd150);
      check("s0_cyc",  32'(wq_cyc[0]),  32'(acc));
    end
    check("s0_done_cyc", 32'(dc), 32'(acc + 1));

    // Servo 5: 20 clamps to 50, ten downward steps.
    clear_q();
    issue(5, 20, acc);
    wait_done(400, dc);
    check("s5_count", 32'(wq_addr.size()), 32'd10);
    for (int i = 0; i < 10 && i < wq_addr.size(); i++) begin
      check("s5_addr", 32'(wq_addr[i]), 32'h14);
      check("s5_data", 32'(wq_data[i]), 32'(140 - 10 * i));
    end
    check("s5_done_cyc", 32'(dc), 32'(acc + 10 * (STEP_DIV + 1)));

    // Servo 2: 175 -> 150 with a competing command offered mid-move.
    clear_q();
    issue(2, 150, acc);
    @(negedge clk);
    check("busy_ready_low", 32'(cmd_ready), 32'd0);
    issue(5, 250, tmp);
    wait_done(200, dc);
    check("s2b_count", 32'(wq_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      check("s2b_addr", 32'(wq_addr[i]), 32'h08);
      check("s2b_data", 32'(wq_data[i]), (i == 2) ? 32'd150 : 32'(165 - 10 * i));
    end
    check("s2b_done_cyc", 32'(dc), 32'(acc + 3 * (STEP_DIV + 1)));

    // Servo 5 must still sit at 50: one step to 60.
    clear_q();
    issue(5, 60, acc);
    wait_done(100, dc);
    check("s5b_count", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() > 0) begin
      check("s5b_addr", 32'(wq_addr[0]), 32'h14);
      check("s5b_data", 32'(wq_data[0]), 32'd60);
      check("s5b_cyc",  32'(wq_cyc[0]),  32'(acc + STEP_DIV));
    end

    // Reset mid-move on servo 7.
    clear_q();
    issue(7, 250, acc);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    nq = wq_addr.size();
    check("abort_pre_writes", 32'(nq), 32'd1);
    @(negedge clk);
    check("abort_cs",    32'(cs),        32'd0);
    check("abort_wr",    32'(wr),        32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    repeat (10) @(negedge clk);
    check("abort_no_writes", 32'(wq_addr.size()), 32'(nq));
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ready(30);

    // Servo 7 restarts from CENTER: 160, 170, 175.
    clear_q();
    issue(7, 175, acc);
    wait_done(200, dc);
    check("s7_count", 32'(wq_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      check("s7_addr", 32'(wq_addr[i]), 32'h1C);
      check("s7_data", 32'(wq_data[i]), (i == 2) ? 32'd175 : 32'(160 + 10 * i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
